// File: rtl/frame_dump_ctrl_pkg.sv
// Shared types and constants for the frame dump sequencer: FSM states,
// sync header bytes, buffer address widths and a byte-select helper.
package frame_dump_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_FETCH,
        ST_SEND,
        ST_WAITB,
        ST_DONE
    } state_t;

    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;

    localparam int X_W = 6;
    localparam int Y_W = 5;

    // Byte idx 0 is the most significant byte of the word.
    function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [31:0] s;
        s = w << {idx, 3'b000};
        return s[31:24];
    endfunction

endpackage

// File: rtl/frame_dump_ctrl_if.sv
// Buffer read port and UART transmitter handshake seen by the dump sequencer.
interface frame_dump_ctrl_if;
    import frame_dump_ctrl_pkg::*;

    logic [X_W-1:0] read_x;
    logic [Y_W-1:0] read_y;
    logic [31:0]    read_data;
    logic           uart_busy;
    logic           uart_wr;
    logic [7:0]     uart_dat;

    modport master (
        output read_x, read_y, uart_wr, uart_dat,
        input  read_data, uart_busy
    );

    modport slave (
        input  read_x, read_y, uart_wr, uart_dat,
        output read_data, uart_busy
    );

endinterface

// File: rtl/frame_dump_ctrl_btn_debounce.sv
// Trigger conditioning: 2-flop synchroniser, saturating low-time counter and
// rising-edge detect; a rise only counts after a fully saturated low period.
module frame_dump_ctrl_btn_debounce #(
    parameter int DEBOUNCE_BITS = 14
) (
    input  logic sys_clk_i,
    input  logic sys_rst_i,
    input  logic trigger_i,
    output logic start_o
);

    localparam int SYNC_STAGES = 2;

    logic [SYNC_STAGES-1:0]   sync_q, sync_d;
    logic                     prev_q, prev_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;
    logic                     cnt_sat;

    assign sync_d[0] = trigger_i;

    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end

    always_comb begin
        cnt_sat = &cnt_q;
        prev_d  = sync_q[SYNC_STAGES-1];
        cnt_d   = cnt_q;
        if (sync_q[SYNC_STAGES-1]) begin
            cnt_d = '0;
        end else if (!cnt_sat) begin
            cnt_d = cnt_q + 1'b1;
        end
        start_o = sync_q[SYNC_STAGES-1] && !prev_q && cnt_sat;
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_dump_ctrl.sv
// One-shot frame buffer dump over the debug UART: walks every (x,y) word and
// sends its 4 bytes MSB first, with a holdoff gap after each transmitter busy period.
module frame_dump_ctrl
    import frame_dump_ctrl_pkg::*;
#(
    parameter int FRAME_W       = 40,
    parameter int FRAME_H       = 30,
    parameter int RD_LAT        = 1,
    parameter int HOLDOFF_BITS  = 13,
    parameter int DEBOUNCE_BITS = 14,
    parameter bit SEND_HEADER   = 1'b1
) (
    input  logic              sys_clk_i,
    input  logic              sys_rst_i,
    input  logic              trigger_i,
    frame_dump_ctrl_if.master bus,
    output logic              busy_o,
    output logic              done_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(FRAME_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(FRAME_H - 1);
    // FETCH spans RD_LAT+1 cycles so the word is sampled after it has been valid a full cycle.
    localparam int             FC_W    = $clog2(RD_LAT + 1);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(RD_LAT);

    state_t                  state_q, state_d;
    logic [X_W-1:0]          x_q, x_d;
    logic [Y_W-1:0]          y_q, y_d;
    logic [1:0]              byte_idx_q, byte_idx_d;
    logic                    hdr_idx_q, hdr_idx_d;
    logic [FC_W-1:0]         fetch_cnt_q, fetch_cnt_d;
    logic [31:0]             word_q, word_d;
    logic [HOLDOFF_BITS-1:0] hold_q, hold_d;
    logic                    wr_q, wr_d;
    logic [7:0]              dat_q, dat_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    hold_sat;
    logic                    ready;
    logic                    start;

    frame_dump_ctrl_btn_debounce #(
        .DEBOUNCE_BITS(DEBOUNCE_BITS)
    ) u_debounce (
        .sys_clk_i(sys_clk_i),
        .sys_rst_i(sys_rst_i),
        .trigger_i(trigger_i),
        .start_o  (start)
    );

    always_comb begin
        hold_sat = &hold_q;
        ready    = hold_sat && !bus.uart_busy;
        if (bus.uart_busy) begin
            hold_d = '0;
        end else if (!hold_sat) begin
            hold_d = hold_q + 1'b1;
        end else begin
            hold_d = hold_q;
        end

        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        byte_idx_d  = byte_idx_q;
        hdr_idx_d   = hdr_idx_q;
        fetch_cnt_d = fetch_cnt_q;
        word_d      = word_q;
        wr_d        = 1'b0;
        dat_d       = dat_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d         = '0;
                    y_d         = '0;
                    byte_idx_d  = '0;
                    hdr_idx_d   = 1'b0;
                    fetch_cnt_d = '0;
                    busy_d      = 1'b1;
                    state_d     = SEND_HEADER ? ST_HDR : ST_FETCH;
                end
            end
            ST_HDR: begin
                // The wr_q guard keeps strobes apart while busy has not yet risen.
                if (ready && !wr_q) begin
                    wr_d      = 1'b1;
                    dat_d     = hdr_idx_q ? HDR_BYTE1 : HDR_BYTE0;
                    hdr_idx_d = 1'b1;
                    if (hdr_idx_q) begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                if (fetch_cnt_q == FC_LAST) begin
                    word_d      = bus.read_data;
                    fetch_cnt_d = '0;
                    state_d     = ST_SEND;
                end else begin
                    fetch_cnt_d = fetch_cnt_q + 1'b1;
                end
            end
            ST_SEND: begin
                if (ready && !wr_q) begin
                    wr_d    = 1'b1;
                    dat_d   = word_byte(word_q, byte_idx_q);
                    state_d = ST_WAITB;
                end
            end
            ST_WAITB: begin
                byte_idx_d = byte_idx_q + 1'b1;
                if (byte_idx_q == 2'd3) begin
                    if (x_q == X_LAST && y_q == Y_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        if (x_q == X_LAST) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q     <= ST_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            byte_idx_q  <= '0;
            hdr_idx_q   <= 1'b0;
            fetch_cnt_q <= '0;
            word_q      <= '0;
            hold_q      <= '0;
            wr_q        <= 1'b0;
            dat_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            byte_idx_q  <= byte_idx_d;
            hdr_idx_q   <= hdr_idx_d;
            fetch_cnt_q <= fetch_cnt_d;
            word_q      <= word_d;
            hold_q      <= hold_d;
            wr_q        <= wr_d;
            dat_q       <= dat_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.read_x   = x_q;
    assign bus.read_y   = y_q;
    assign bus.uart_wr  = wr_q;
    assign bus.uart_dat = dat_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;

endmodule

// File: tb/tb_frame_dump_ctrl.sv
// Bench for frame_dump_ctrl: two instances (header/RD_LAT=1 and no header/RD_LAT=2)
// against a byte-stream scoreboard, a registered-read buffer model and a busy-for-10 UART model.
module tb_frame_dump_ctrl;

    localparam int FW        = 3;
    localparam int FH        = 2;
    localparam int HB        = 3;
    localparam int DB        = 2;
    localparam int HOLD      = (1 << HB) - 1;
    localparam int UART_BUSY = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic trig [2];

    logic [5:0]  rx    [2];
    logic [4:0]  ry    [2];
    logic        wr    [2];
    logic [7:0]  dat   [2];
    logic [31:0] rdata [2];
    logic        ubusy [2];
    logic        dbusy [2];
    logic        ddone [2];

    logic [31:0] mem   [2][FH][FW];
    logic [7:0]  exp_q [2][64];
    int          exp_n [2];
    int          exp_p [2];
    int          bytes [2];
    int          done_cnt [2];
    int          starts [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    frame_dump_ctrl_if bus0 ();
    frame_dump_ctrl_if bus1 ();

    assign rx[0]  = bus0.read_x;
    assign ry[0]  = bus0.read_y;
    assign wr[0]  = bus0.uart_wr;
    assign dat[0] = bus0.uart_dat;
    assign bus0.read_data = rdata[0];
    assign bus0.uart_busy = ubusy[0];
    assign rx[1]  = bus1.read_x;
    assign ry[1]  = bus1.read_y;
    assign wr[1]  = bus1.uart_wr;
    assign dat[1] = bus1.uart_dat;
    assign bus1.read_data = rdata[1];
    assign bus1.uart_busy = ubusy[1];

    frame_dump_ctrl #(
        .FRAME_W(FW), .FRAME_H(FH), .RD_LAT(1), .HOLDOFF_BITS(HB),
        .DEBOUNCE_BITS(DB), .SEND_HEADER(1'b1)
    ) dut0 (
        .sys_clk_i(clk), .sys_rst_i(rst), .trigger_i(trig[0]),
        .bus(bus0), .busy_o(dbusy[0]), .done_o(ddone[0])
    );

    frame_dump_ctrl #(
        .FRAME_W(FW), .FRAME_H(FH), .RD_LAT(2), .HOLDOFF_BITS(HB),
        .DEBOUNCE_BITS(DB), .SEND_HEADER(1'b0)
    ) dut1 (
        .sys_clk_i(clk), .sys_rst_i(rst), .trigger_i(trig[1]),
        .bus(bus1), .busy_o(dbusy[1]), .done_o(ddone[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] word_at(input int i, input logic [5:0] x, input logic [4:0] y);
        if (int'(x) < FW && int'(y) < FH) return mem[i][y][x];
        return 32'hDEAD_BEEF;
    endfunction

    // Expected byte stream for a full dump: optional header, then rows, columns, MSB first.
    task automatic build_exp(input int i);
        exp_n[i] = 0;
        exp_p[i] = 0;
        bytes[i] = 0;
        if (i == 0) begin
            exp_q[i][0] = 8'hA5;
            exp_q[i][1] = 8'h5A;
            exp_n[i] = 2;
        end
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                for (int b = 0; b < 4; b++) begin
                    exp_q[i][exp_n[i]] = 8'((mem[i][y][x] >> (24 - 8 * b)) & 32'hFF);
                    exp_n[i]++;
                end
    endtask

    task automatic fill_random(input int i);
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                mem[i][y][x] = $urandom;
    endtask

    // Buffer, UART and scoreboard model for instance i, evaluated on falling edges.
    task automatic model(input int i);
        int          ucnt      = 0;
        int          gap       = 1000;
        logic        prev_wr   = 1'b0;
        logic        prev_busy = 1'b0;
        logic        prev_rst  = 1'b0;
        logic [10:0] prev_addr = '0;
        logic [31:0] pipe0     = '0;
        logic [31:0] pipe1     = '0;
        forever begin
            @(negedge clk);
            if ({rx[i], ry[i]} != prev_addr)
                chk($sformatf("addr_move_i%0d", i),
                    {31'b0, prev_wr | prev_rst | (dbusy[i] & ~prev_busy)}, 32'd1);
            rdata[i] = (i == 0) ? pipe0 : pipe1;
            pipe1 = pipe0;
            pipe0 = word_at(i, rx[i], ry[i]);
            if (wr[i]) begin
                bytes[i]++;
                chk($sformatf("gap_i%0d_b%0d", i, bytes[i]), (gap >= HOLD) ? HOLD : gap, HOLD);
                if (exp_p[i] < exp_n[i]) begin
                    chk($sformatf("byte_i%0d_n%0d", i, exp_p[i]), {24'b0, dat[i]}, {24'b0, exp_q[i][exp_p[i]]});
                    exp_p[i]++;
                end else begin
                    chk($sformatf("extra_byte_i%0d", i), bytes[i], exp_n[i]);
                end
                ubusy[i] = 1'b1;
                ucnt = UART_BUSY;
                gap = 0;
            end else if (ucnt > 0) begin
                ucnt--;
                if (ucnt == 0) ubusy[i] = 1'b0;
            end else begin
                gap++;
            end
            if (ddone[i]) begin
                done_cnt[i]++;
                chk($sformatf("done_len_i%0d", i), exp_p[i], exp_n[i]);
                chk($sformatf("done_busy_i%0d", i), {31'b0, dbusy[i]}, 32'd0);
                chk($sformatf("busy_before_done_i%0d", i), {31'b0, prev_busy}, 32'd1);
            end
            if (dbusy[i] && !prev_busy) starts[i]++;
            prev_wr   = wr[i];
            prev_busy = dbusy[i];
            prev_rst  = rst;
            prev_addr = {rx[i], ry[i]};
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int i, input string tag);
        int start_cnt;
        int n;
        start_cnt = done_cnt[i];
        n = 0;
        while (done_cnt[i] == start_cnt && n < 3000) begin
            cyc(1);
            n++;
        end
        cyc(2);
        chk(tag, done_cnt[i] - start_cnt, 32'd1);
    endtask

    task automatic check_idle_outputs(input int i, input string tag);
        chk({tag, "_x"},    {26'b0, rx[i]}, 32'd0);
        chk({tag, "_y"},    {27'b0, ry[i]}, 32'd0);
        chk({tag, "_wr"},   {31'b0, wr[i]}, 32'd0);
        chk({tag, "_dat"},  {24'b0, dat[i]}, 32'd0);
        chk({tag, "_busy"}, {31'b0, dbusy[i]}, 32'd0);
        chk({tag, "_done"}, {31'b0, ddone[i]}, 32'd0);
    endtask

    initial begin
        int s0;
        int d0;
        trig[0] = 1'b0;
        trig[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rdata[i] = '0;
            ubusy[i] = 1'b0;
            exp_n[i] = 0;
            exp_p[i] = 0;
            bytes[i] = 0;
            done_cnt[i] = 0;
            starts[i] = 0;
        end
        fork
            model(0);
            model(1);
        join_none

        cyc(3);
        check_idle_outputs(0, "reset_i0");
        check_idle_outputs(1, "reset_i1");
        rst = 1'b0;

        // Dump with the {y,x,C3,3C} pattern.
        for (int y = 0; y < FH; y++)
            for (int x = 0; x < FW; x++)
                mem[0][y][x] = {8'(y), 8'(x), 8'hC3, 8'h3C};
        build_exp(0);
        cyc(10);
        trig[0] = 1'b1;
        wait_done(0, "t1_done");
        chk("t1_bytes", bytes[0], 32'd26);
        $display("t1 pattern dump: bytes=%0d done=%0d", bytes[0], done_cnt[0]);

        // Short bounce right after the dump must not start a new one.
        s0 = starts[0];
        trig[0] = 1'b0;
        cyc(1);
        trig[0] = 1'b1;
        cyc(40);
        chk("t2_bounce_ignored", starts[0], s0);
        fill_random(0);
        build_exp(0);
        trig[0] = 1'b0;
        cyc(10);
        trig[0] = 1'b1;
        wait_done(0, "t2_clean_done");
        chk("t2_bytes", bytes[0], 32'd26);
        $display("t2 bounce then clean dump: bytes=%0d", bytes[0]);

        // Clean rise mid-dump is ignored.
        fill_random(0);
        build_exp(0);
        s0 = starts[0];
        trig[0] = 1'b0;
        cyc(10);
        trig[0] = 1'b1;
        cyc(100);
        trig[0] = 1'b0;
        cyc(10);
        trig[0] = 1'b1;
        wait_done(0, "t4_done");
        chk("t4_bytes", bytes[0], 32'd26);
        chk("t4_one_start", starts[0], s0 + 1);
        cyc(40);
        chk("t4_no_late_start", starts[0], s0 + 1);
        $display("t4 mid-dump retrigger: bytes=%0d starts=%0d", bytes[0], starts[0] - s0);

        // Reset after byte 9, then restart from x=y=0.
        fill_random(0);
        build_exp(0);
        trig[0] = 1'b0;
        cyc(10);
        trig[0] = 1'b1;
        begin
            int n;
            n = 0;
            while (bytes[0] < 9 && n < 2000) begin
                cyc(1);
                n++;
            end
        end
        chk("t5_reach9", bytes[0], 32'd9);
        d0 = done_cnt[0];
        rst = 1'b1;
        cyc(1);
        check_idle_outputs(0, "t5_rst");
        rst = 1'b0;
        cyc(60);
        chk("t5_no_done", done_cnt[0], d0);
        fill_random(0);
        build_exp(0);
        trig[0] = 1'b0;
        cyc(10);
        trig[0] = 1'b1;
        wait_done(0, "t5_restart_done");
        chk("t5_bytes", bytes[0], 32'd26);
        $display("t5 reset mid-dump and restart: bytes=%0d", bytes[0]);

        // No header, two-cycle read latency.
        fill_random(1);
        build_exp(1);
        trig[1] = 1'b0;
        cyc(10);
        trig[1] = 1'b1;
        wait_done(1, "t6_done");
        chk("t6_bytes", bytes[1], 32'd24);
        chk("t6_one_start", starts[1], 32'd1);
        $display("t6 no header rd_lat=2: bytes=%0d", bytes[1]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
